// File: rtl/seq_packet_serializer_if.sv
// Bundles the seq packet input port and the per-sequence output stream of the serializer.
// The slave modport is the serializer itself; the master modport is the surrounding logic.
interface seq_packet_serializer_if #(
    parameter int PACKET_SIZE  = 4,
    parameter int LL_BITS      = 16,
    parameter int ML_BITS      = 16,
    parameter int OFFSET_BITS  = 17,
    parameter int JOB_LEN_BITS = 24
) ();
    logic                               i_valid;
    logic                               i_ready;
    logic [PACKET_SIZE-1:0]             i_mask;
    logic [PACKET_SIZE*LL_BITS-1:0]     i_ll;
    logic [PACKET_SIZE*ML_BITS-1:0]     i_ml;
    logic [PACKET_SIZE*OFFSET_BITS-1:0] i_offset;
    logic [ML_BITS-1:0]                 i_overlap;
    logic                               i_eoj;
    logic                               i_delim;

    logic                               o_valid;
    logic                               o_ready;
    logic                               o_empty;
    logic [LL_BITS-1:0]                 o_ll;
    logic [ML_BITS-1:0]                 o_ml;
    logic [OFFSET_BITS-1:0]             o_offset;
    logic                               o_last;
    logic                               o_eoj;
    logic                               o_delim;
    logic [ML_BITS-1:0]                 o_overlap;
    logic [JOB_LEN_BITS-1:0]            o_job_len;

    modport master (
        output i_valid, i_mask, i_ll, i_ml, i_offset, i_overlap, i_eoj, i_delim, o_ready,
        input  i_ready, o_valid, o_empty, o_ll, o_ml, o_offset, o_last, o_eoj, o_delim,
               o_overlap, o_job_len
    );

    modport slave (
        input  i_valid, i_mask, i_ll, i_ml, i_offset, i_overlap, i_eoj, i_delim, o_ready,
        output i_ready, o_valid, o_empty, o_ll, o_ml, o_offset, o_last, o_eoj, o_delim,
               o_overlap, o_job_len
    );
endinterface

// File: rtl/seq_packet_serializer.sv
// Buffers one seq packet and emits its valid lanes one per cycle, lowest lane first,
// tracking the running ll+ml byte count of the current job.
module seq_packet_serializer #(
    parameter int PACKET_SIZE  = 4,
    parameter int LL_BITS      = 16,
    parameter int ML_BITS      = 16,
    parameter int OFFSET_BITS  = 17,
    parameter int JOB_LEN_BITS = 24
) (
    input logic                  clk,
    input logic                  rst,
    seq_packet_serializer_if.slave bus
);
    localparam int IDX_W = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;

    logic                               buf_valid;
    logic [PACKET_SIZE-1:0]             rem;
    logic [PACKET_SIZE*LL_BITS-1:0]     buf_ll;
    logic [PACKET_SIZE*ML_BITS-1:0]     buf_ml;
    logic [PACKET_SIZE*OFFSET_BITS-1:0] buf_offset;
    logic [ML_BITS-1:0]                 buf_overlap;
    logic                               buf_eoj;
    logic                               buf_delim;
    logic [JOB_LEN_BITS-1:0]            job_acc;

    logic [IDX_W-1:0]                   cur;
    logic [PACKET_SIZE-1:0]             rem_next;
    logic                               has_lane;
    logic                               is_last;
    logic                               in_ready;
    logic                               accept;
    logic                               fire;
    logic [LL_BITS-1:0]                 out_ll;
    logic [ML_BITS-1:0]                 out_ml;
    logic [OFFSET_BITS-1:0]             out_offset;
    logic                               out_eoj;
    logic [JOB_LEN_BITS-1:0]            job_len;

    // Priority encoder: lowest remaining lane wins.
    always_comb begin
        cur = '0;
        for (int k = PACKET_SIZE - 1; k >= 0; k--) begin
            if (rem[k]) begin
                cur = IDX_W'(k);
            end
        end
    end

    assign rem_next = rem & (rem - PACKET_SIZE'(1));
    assign has_lane = |rem;
    assign is_last  = buf_valid && (rem_next == '0);

    assign out_ll     = (buf_valid && has_lane) ? buf_ll[cur*LL_BITS +: LL_BITS] : '0;
    assign out_ml     = (buf_valid && has_lane) ? buf_ml[cur*ML_BITS +: ML_BITS] : '0;
    assign out_offset = (buf_valid && has_lane) ? buf_offset[cur*OFFSET_BITS +: OFFSET_BITS] : '0;
    assign out_eoj    = is_last && buf_eoj;
    assign job_len    = job_acc + JOB_LEN_BITS'(out_ll) + JOB_LEN_BITS'(out_ml);

    // The last beat's handshake frees the buffer in the same cycle, so packets chain bubble-free.
    assign in_ready = !buf_valid || (bus.o_ready && is_last);
    assign accept   = bus.i_valid && in_ready;
    assign fire     = buf_valid && bus.o_ready;

    assign bus.i_ready   = in_ready;
    assign bus.o_valid   = buf_valid;
    assign bus.o_empty   = buf_valid && !has_lane;
    assign bus.o_ll      = out_ll;
    assign bus.o_ml      = out_ml;
    assign bus.o_offset  = out_offset;
    assign bus.o_last    = is_last;
    assign bus.o_eoj     = out_eoj;
    assign bus.o_delim   = is_last && buf_delim;
    assign bus.o_overlap = out_eoj ? buf_overlap : '0;
    assign bus.o_job_len = job_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid   <= 1'b0;
            rem         <= '0;
            buf_ll      <= '0;
            buf_ml      <= '0;
            buf_offset  <= '0;
            buf_overlap <= '0;
            buf_eoj     <= 1'b0;
            buf_delim   <= 1'b0;
            job_acc     <= '0;
        end else begin
            if (accept) begin
                buf_valid   <= 1'b1;
                rem         <= bus.i_mask;
                buf_ll      <= bus.i_ll;
                buf_ml      <= bus.i_ml;
                buf_offset  <= bus.i_offset;
                buf_overlap <= bus.i_overlap;
                buf_eoj     <= bus.i_eoj;
                buf_delim   <= bus.i_delim;
            end else if (fire) begin
                rem <= rem_next;
                if (is_last) begin
                    buf_valid <= 1'b0;
                end
            end
            // Overlap is left in the total; the consumer trims it using o_overlap.
            if (fire) begin
                job_acc <= out_eoj ? '0 : job_len;
            end
        end
    end
endmodule

// File: tb/tb_seq_packet_serializer.sv
// Directed, table-driven bench for seq_packet_serializer plus a job-length wrap check
// on a second instance with an 8-bit accumulator.
module tb_seq_packet_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_packet_serializer_if #(.PACKET_SIZE(4), .LL_BITS(16), .ML_BITS(16), .OFFSET_BITS(17),
                               .JOB_LEN_BITS(24)) bus ();
    seq_packet_serializer_if #(.PACKET_SIZE(4), .LL_BITS(16), .ML_BITS(16), .OFFSET_BITS(17),
                               .JOB_LEN_BITS(8)) wbus ();

    seq_packet_serializer #(.PACKET_SIZE(4), .LL_BITS(16), .ML_BITS(16), .OFFSET_BITS(17),
                            .JOB_LEN_BITS(24)) dut (.clk(clk), .rst(rst), .bus(bus));
    seq_packet_serializer #(.PACKET_SIZE(4), .LL_BITS(16), .ML_BITS(16), .OFFSET_BITS(17),
                            .JOB_LEN_BITS(8)) wdut (.clk(clk), .rst(rst), .bus(wbus));

    typedef struct {
        string       name;
        logic        rst;
        logic        in_valid;
        logic [3:0]  mask;
        logic [63:0] ll;
        logic [63:0] ml;
        logic [67:0] off;
        logic [15:0] overlap;
        logic        eoj;
        logic        delim;
        logic        rdy;
        logic        e_iready;
        logic        e_valid;
        logic        e_empty;
        int          e_ll;
        int          e_ml;
        int          e_off;
        logic        e_last;
        logic        e_eoj;
        logic        e_delim;
        int          e_overlap;
        int          e_job;
    } vec_t;

    vec_t vecs[$];

    logic [3:0]  s_mask;
    logic [63:0] s_ll;
    logic [63:0] s_ml;
    logic [67:0] s_off;
    logic [15:0] s_ovl;
    logic        s_eoj;
    logic        s_delim;

    task automatic stage(input logic [3:0] m, input logic [63:0] l, input logic [63:0] ml,
                         input logic [67:0] o, input logic [15:0] ov, input logic e,
                         input logic d);
        s_mask = m; s_ll = l; s_ml = ml; s_off = o; s_ovl = ov; s_eoj = e; s_delim = d;
    endtask

    task automatic add(input string n, input bit r, input bit v, input bit rdy,
                       input bit er, input bit ev, input bit eem, input int ell, input int eml,
                       input int eoff, input bit elast, input bit eeoj, input bit edel,
                       input int eovl, input int ejob);
        vec_t t;
        t.name = n; t.rst = r; t.in_valid = v; t.rdy = rdy;
        t.mask = s_mask; t.ll = s_ll; t.ml = s_ml; t.off = s_off;
        t.overlap = s_ovl; t.eoj = s_eoj; t.delim = s_delim;
        t.e_iready = er; t.e_valid = ev; t.e_empty = eem;
        t.e_ll = ell; t.e_ml = eml; t.e_off = eoff;
        t.e_last = elast; t.e_eoj = eeoj; t.e_delim = edel;
        t.e_overlap = eovl; t.e_job = ejob;
        vecs.push_back(t);
    endtask

    task automatic checkOutput(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d", n, act, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of posedge.
    task automatic applyStimulus(input vec_t t);
        @(negedge clk);
        rst           = t.rst;
        bus.i_valid   = t.in_valid;
        bus.i_mask    = t.mask;
        bus.i_ll      = t.ll;
        bus.i_ml      = t.ml;
        bus.i_offset  = t.off;
        bus.i_overlap = t.overlap;
        bus.i_eoj     = t.eoj;
        bus.i_delim   = t.delim;
        bus.o_ready   = t.rdy;
        #1;
    endtask

    task automatic checkVector(input vec_t t);
        checkOutput({t.name, ".i_ready"},   32'(bus.i_ready),   32'(t.e_iready));
        checkOutput({t.name, ".o_valid"},   32'(bus.o_valid),   32'(t.e_valid));
        checkOutput({t.name, ".o_empty"},   32'(bus.o_empty),   32'(t.e_empty));
        checkOutput({t.name, ".o_ll"},      32'(bus.o_ll),      32'(t.e_ll));
        checkOutput({t.name, ".o_ml"},      32'(bus.o_ml),      32'(t.e_ml));
        checkOutput({t.name, ".o_offset"},  32'(bus.o_offset),  32'(t.e_off));
        checkOutput({t.name, ".o_last"},    32'(bus.o_last),    32'(t.e_last));
        checkOutput({t.name, ".o_eoj"},     32'(bus.o_eoj),     32'(t.e_eoj));
        checkOutput({t.name, ".o_delim"},   32'(bus.o_delim),   32'(t.e_delim));
        checkOutput({t.name, ".o_overlap"}, 32'(bus.o_overlap), 32'(t.e_overlap));
        checkOutput({t.name, ".o_job_len"}, 32'(bus.o_job_len), 32'(t.e_job));
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_mask = '0; bus.i_ll = '0; bus.i_ml = '0; bus.i_offset = '0;
        bus.i_overlap = '0; bus.i_eoj = 1'b0; bus.i_delim = 1'b0; bus.o_ready = 1'b1;
        wbus.i_valid = 1'b0; wbus.i_mask = '0; wbus.i_ll = '0; wbus.i_ml = '0;
        wbus.i_offset = '0; wbus.i_overlap = '0; wbus.i_eoj = 1'b0; wbus.i_delim = 1'b0;
        wbus.o_ready = 1'b1;

        // Single packet, lanes 0,1,3; lane 2 carries X that must never surface.
        stage(4'b1011, {16'd7, 16'bx, 16'd3, 16'd5}, {16'd8, 16'd77, 16'd6, 16'd4},
              {17'd400, 17'd300, 17'd200, 17'd100}, 16'd2, 1'b1, 1'b0);
        add("reset_hold",   1, 0, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        add("p1_accept",    0, 1, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        add("p1_lane0",     0, 0, 1,  0, 1, 0,  5, 4, 100,  0, 0, 0, 0,  9);
        add("p1_lane1",     0, 0, 1,  0, 1, 0,  3, 6, 200,  0, 0, 0, 0,  18);
        add("p1_lane3",     0, 0, 1,  1, 1, 0,  7, 8, 400,  1, 1, 0, 2,  33);
        add("p1_idle",      0, 0, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        // Back-to-back full packets.
        stage(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd40, 16'd30, 16'd20, 16'd10},
              {17'd14, 17'd13, 17'd12, 17'd11}, 16'd0, 1'b0, 1'b0);
        add("b2b_accept",   0, 1, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        stage(4'b1111, {16'd8, 16'd7, 16'd6, 16'd5}, {16'd1, 16'd1, 16'd1, 16'd1},
              {17'd24, 17'd23, 17'd22, 17'd21}, 16'd3, 1'b1, 1'b1);
        add("b2b_a_lane0",  0, 1, 1,  0, 1, 0,  1, 10, 11,  0, 0, 0, 0,  11);
        add("b2b_a_lane1",  0, 1, 1,  0, 1, 0,  2, 20, 12,  0, 0, 0, 0,  33);
        add("b2b_a_lane2",  0, 1, 1,  0, 1, 0,  3, 30, 13,  0, 0, 0, 0,  66);
        add("b2b_a_lane3",  0, 1, 1,  1, 1, 0,  4, 40, 14,  1, 0, 0, 0,  110);
        add("b2b_b_lane0",  0, 0, 1,  0, 1, 0,  5, 1, 21,   0, 0, 0, 0,  116);
        add("b2b_b_lane1",  0, 0, 1,  0, 1, 0,  6, 1, 22,   0, 0, 0, 0,  123);
        add("b2b_b_lane2",  0, 0, 1,  0, 1, 0,  7, 1, 23,   0, 0, 0, 0,  131);
        add("b2b_b_lane3",  0, 0, 1,  1, 1, 0,  8, 1, 24,   1, 1, 1, 3,  140);
        add("b2b_idle",     0, 0, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        // Backpressure with delim but no eoj: overlap suppressed, accumulator kept.
        stage(4'b0110, {16'd53, 16'd52, 16'd51, 16'd50}, {16'd63, 16'd62, 16'd61, 16'd60},
              {17'd73, 17'd72, 17'd71, 17'd70}, 16'd9, 1'b0, 1'b1);
        add("bp_accept",    0, 1, 0,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        add("bp_l1_stall0", 0, 0, 0,  0, 1, 0,  51, 61, 71, 0, 0, 0, 0,  112);
        add("bp_l1_stall1", 0, 0, 0,  0, 1, 0,  51, 61, 71, 0, 0, 0, 0,  112);
        add("bp_l1_go",     0, 0, 1,  0, 1, 0,  51, 61, 71, 0, 0, 0, 0,  112);
        add("bp_l2_stall0", 0, 0, 0,  0, 1, 0,  52, 62, 72, 1, 0, 1, 0,  226);
        add("bp_l2_stall1", 0, 0, 0,  0, 1, 0,  52, 62, 72, 1, 0, 1, 0,  226);
        add("bp_l2_go",     0, 0, 1,  1, 1, 0,  52, 62, 72, 1, 0, 1, 0,  226);
        add("bp_idle",      0, 0, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  226);
        // Reset while a packet sits in the buffer.
        stage(4'b1111, {16'd1, 16'd1, 16'd1, 16'd1}, {16'd1, 16'd1, 16'd1, 16'd1},
              {17'd5, 17'd5, 17'd5, 17'd5}, 16'd0, 1'b1, 1'b0);
        add("rst_stale_acc", 0, 1, 0, 1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  226);
        add("rst_mid0",     1, 0, 0,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        add("rst_mid1",     1, 0, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        add("rst_mid2",     1, 0, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        add("rst_release",  0, 0, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        add("rst_no_stale", 0, 0, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        // 40-byte non-eoj packet followed by an empty eoj/delim marker.
        stage(4'b0011, {16'd0, 16'd0, 16'd5, 16'd10}, {16'd0, 16'd0, 16'd5, 16'd20},
              {17'd4, 17'd3, 17'd2, 17'd1}, 16'd0, 1'b0, 1'b0);
        add("mk_prev_acc",  0, 1, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        stage(4'b0000, {16'd9, 16'd9, 16'd9, 16'd9}, {16'd9, 16'd9, 16'd9, 16'd9},
              {17'd9, 17'd9, 17'd9, 17'd9}, 16'd4, 1'b1, 1'b1);
        add("mk_prev_l0",   0, 1, 1,  0, 1, 0,  10, 20, 1,  0, 0, 0, 0,  30);
        add("mk_prev_l1",   0, 1, 1,  1, 1, 0,  5, 5, 2,    1, 0, 0, 0,  40);
        add("mk_empty",     0, 0, 1,  1, 1, 1,  0, 0, 0,    1, 1, 1, 4,  40);
        stage(4'b0100, {16'd0, 16'd3, 16'd0, 16'd0}, {16'd0, 16'd4, 16'd0, 16'd0},
              {17'd0, 17'd33, 17'd0, 17'd0}, 16'd0, 1'b0, 1'b0);
        add("nj_accept",    0, 1, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  0);
        add("nj_lane2",     0, 0, 1,  1, 1, 0,  3, 4, 33,   1, 0, 0, 0,  7);
        add("nj_idle",      0, 0, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  7);
        // Mask-0 packet with no eoj/delim still yields one marker beat.
        stage(4'b0000, {16'd2, 16'd2, 16'd2, 16'd2}, {16'd2, 16'd2, 16'd2, 16'd2},
              {17'd2, 17'd2, 17'd2, 17'd2}, 16'd5, 1'b0, 1'b0);
        add("pe_accept",    0, 1, 0,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  7);
        add("pe_stall",     0, 0, 0,  0, 1, 1,  0, 0, 0,    1, 0, 0, 0,  7);
        add("pe_go",        0, 0, 1,  1, 1, 1,  0, 0, 0,    1, 0, 0, 0,  7);
        add("pe_idle",      0, 0, 1,  1, 0, 0,  0, 0, 0,    0, 0, 0, 0,  7);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i]);
        end

        // Accumulator wrap on the 8-bit instance: 200 + 200 + 0 = 400 mod 256 = 144.
        @(negedge clk);
        wbus.i_valid = 1'b1; wbus.i_mask = 4'b0111; wbus.i_eoj = 1'b1; wbus.i_overlap = 16'd1;
        wbus.i_ll = {16'd0, 16'd0, 16'd150, 16'd100};
        wbus.i_ml = {16'd0, 16'd0, 16'd50, 16'd100};
        #1;
        checkOutput("wrap.accept_ready", 32'(wbus.i_ready), 32'd1);
        @(negedge clk);
        wbus.i_valid = 1'b0;
        #1;
        checkOutput("wrap.beat0_job", 32'(wbus.o_job_len), 32'd200);
        checkOutput("wrap.beat0_eoj", 32'(wbus.o_eoj), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("wrap.beat1_job", 32'(wbus.o_job_len), 32'd144);
        @(negedge clk);
        #1;
        checkOutput("wrap.beat2_job", 32'(wbus.o_job_len), 32'd144);
        checkOutput("wrap.beat2_eoj", 32'(wbus.o_eoj), 32'd1);
        checkOutput("wrap.beat2_overlap", 32'(wbus.o_overlap), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("wrap.after_valid", 32'(wbus.o_valid), 32'd0);
        checkOutput("wrap.after_job", 32'(wbus.o_job_len), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
